modn_counter: RTL and testbench
===============================

MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 Parameter MODULUS, default 60: count range 0..MODULUS-1; legal range 2..100.
REQ-002 Parameter WIDTH, default 7: count register width; SHALL satisfy 2**WIDTH >= MODULUS.
REQ-003 Parameter RESET_VAL, default 0: value loaded on reset; SHALL be < MODULUS.
REQ-004 cnt_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 cnt_rst  input  1  reset, synchronous, active-high.
REQ-006 cnt_en  input  1  count enable; one step per cycle while high in RUN.
REQ-007 cnt_dir  input  1  direction: 0 = up, 1 = down.
REQ-008 cnt_load  input  1  synchronous load strobe.
REQ-009 cnt_load_val  input  WIDTH  value for load.
REQ-010 cnt_set_mode  input  1  1 = SET state (manual adjust), 0 = RUN state.
REQ-011 cnt_set_inc  input  1  manual increment; level input, acted on at rising edge.
REQ-012 cnt_set_dec  input  1  manual decrement; level input, acted on at rising edge.
REQ-013 cnt_value  output  WIDTH  current count (registered).
REQ-014 cnt_tens  output  4  BCD tens digit of cnt_value (combinational).
REQ-015 cnt_ones  output  4  BCD ones digit of cnt_value (combinational).
REQ-016 cnt_tc  output  1  terminal-count level (combinational), for cascading into next stage's cnt_en.
REQ-017 cnt_carry  output  1  registered one-cycle pulse on up-wrap.
REQ-018 cnt_borrow  output  1  registered one-cycle pulse on down-wrap.
REQ-019 cnt_load_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-020 State machine: RUN and SET; state register takes cnt_set_mode each cycle; RUN->SET and SET->RUN effective the cycle after cnt_set_mode changes.
REQ-021 Priority per cycle: reset > load > SET adjust > RUN count.
REQ-022 Load: cnt_load=1 and cnt_load_val < MODULUS -> cnt_value = cnt_load_val next cycle, in either state; no carry/borrow.
REQ-023 Load with cnt_load_val >= MODULUS -> cnt_value unchanged, cnt_load_err = 1 for one cycle.
REQ-024 RUN, cnt_en=1, up: value+1; at MODULUS-1 wraps to 0 and cnt_carry = 1 the following cycle (same edge as wrap).
REQ-025 RUN, cnt_en=1, down: value-1; at 0 wraps to MODULUS-1 and cnt_borrow = 1 on same edge as wrap.
REQ-026 RUN, cnt_en=0: value held, carry/borrow 0.
REQ-027 SET: cnt_en ignored; rising edge of cnt_set_inc (current=1, previous sample=0) -> +1 with wrap; rising edge of cnt_set_dec -> -1 with wrap; no carry/borrow in SET.
REQ-028 SET: simultaneous rising edges of inc and dec -> no change.
REQ-029 Held-high inc/dec produces exactly one step; edge-detect sample registers update every cycle regardless of state.
REQ-030 cnt_tc = 1 when state RUN and ((cnt_dir=0 and value=MODULUS-1) or (cnt_dir=1 and value=0)); 0 in SET.
REQ-031 cnt_tens = value/10, cnt_ones = value mod 10, for all value 0..MODULUS-1.
REQ-032 cnt_carry, cnt_borrow, cnt_load_err are 0 in every cycle not explicitly pulsing them; never two consecutive 1s from a single event.
REQ-033 cnt_value never leaves 0..MODULUS-1 under any input sequence.

Reset
REQ-034 cnt_rst=1 at a rising edge -> cnt_value=RESET_VAL, state RUN, carry/borrow/load_err=0, edge-detect registers=0, overriding load, set and count.
REQ-035 Reset mid-count or mid-SET takes effect on that edge; first step after release occurs on the next edge with cnt_en=1.

Verification
REQ-036 Defaults, reset, cnt_en=1 up 60 cycles -> value 0..59 then 0; cnt_carry=1 exactly the cycle value returns to 0; cnt_tc=1 while value=59.
REQ-037 Down from 0 with cnt_en=1 -> value 59, cnt_borrow one-cycle pulse; tens=5, ones=9.
REQ-038 Load 42 -> value 42, tens 4, ones 2; load 60 -> value unchanged, cnt_load_err single pulse.
REQ-039 SET, cnt_set_inc held high 5 cycles at value 59 -> value 0 once, no carry; inc and dec rising together -> unchanged.
REQ-040 Reset asserted mid-run with load=1 same cycle -> value RESET_VAL, no load_err; MODULUS=24, WIDTH=5 instance wraps 23->0 with carry.

Source files
------------

// File: rtl/modn_counter.sv
// Modulo-N up/down counter with load, manual SET adjust, BCD digit outputs and cascade signals.
// Carry/borrow/load-error are registered one-cycle pulses; tc and BCD digits are combinational.
module modn_counter #(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             cnt_en,
    input  logic             cnt_dir,
    input  logic             cnt_load,
    input  logic [WIDTH-1:0] cnt_load_val,
    input  logic             cnt_set_mode,
    input  logic             cnt_set_inc,
    input  logic             cnt_set_dec,
    output logic [WIDTH-1:0] cnt_value,
    output logic [3:0]       cnt_tens,
    output logic [3:0]       cnt_ones,
    output logic             cnt_tc,
    output logic             cnt_carry,
    output logic             cnt_borrow,
    output logic             cnt_load_err
);

    localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

    typedef enum logic [0:0] {StRun, StSet} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;
    logic             inc_prev_q, dec_prev_q;

    logic             load_ok;
    logic             inc_rise, dec_rise;
    logic [WIDTH-1:0] value_up, value_dn;

    // Compare in 32 bits so MODULUS == 2**WIDTH still rejects nothing spuriously.
    assign load_ok  = 32'(cnt_load_val) < MODULUS;
    assign inc_rise = cnt_set_inc & ~inc_prev_q;
    assign dec_rise = cnt_set_dec & ~dec_prev_q;
    assign value_up = (value_q == MaxVal) ? '0 : value_q + WIDTH'(1);
    assign value_dn = (value_q == '0) ? MaxVal : value_q - WIDTH'(1);

    // State register
    always_ff @(posedge cnt_clk) begin
        if (cnt_rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: mode input is simply registered
    always_comb begin
        state_d = cnt_set_mode ? StSet : StRun;
    end

    // Datapath next-state: load > SET adjust > RUN count
    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (cnt_load) begin
            if (load_ok) begin
                value_d = cnt_load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (state_q == StSet) begin
            if (inc_rise && !dec_rise) begin
                value_d = value_up;
            end else if (dec_rise && !inc_rise) begin
                value_d = value_dn;
            end
        end else if (cnt_en) begin
            if (!cnt_dir) begin
                value_d = value_up;
                carry_d = (value_q == MaxVal);
            end else begin
                value_d  = value_dn;
                borrow_d = (value_q == '0);
            end
        end
    end

    always_ff @(posedge cnt_clk) begin
        if (cnt_rst) begin
            value_q    <= ResetVal;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
            inc_prev_q <= cnt_set_inc;
            dec_prev_q <= cnt_set_dec;
        end
    end

    // Outputs
    always_comb begin
        cnt_tc = 1'b0;
        unique case (state_q)
            StRun:   cnt_tc = cnt_dir ? (value_q == '0) : (value_q == MaxVal);
            StSet:   cnt_tc = 1'b0;
            default: cnt_tc = 1'b0;
        endcase
    end

    // BCD split by range search; value never exceeds 99
    always_comb begin
        int v;
        v        = int'(value_q);
        cnt_tens = 4'd0;
        cnt_ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v >= i * 10 && v < i * 10 + 10) begin
                cnt_tens = 4'(i);
                cnt_ones = 4'(v - i * 10);
            end
        end
    end

    assign cnt_value    = value_q;
    assign cnt_carry    = carry_q;
    assign cnt_borrow   = borrow_q;
    assign cnt_load_err = load_err_q;

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench for modn_counter: two instances (mod 60 and mod 24) share stimulus;
// an arithmetic reference model queues expectations that a monitor compares after each edge.
module tb_modn_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic       set_mode = 1'b0, set_inc = 1'b0, set_dec = 1'b0;
    logic [6:0] load_val = '0;

    logic [6:0] a_value;
    logic [4:0] b_value;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic       a_tc, a_carry, a_borrow, a_err;
    logic       b_tc, b_carry, b_borrow, b_err;

    always #5 clk = ~clk;

    modn_counter dut_a (
        .cnt_clk(clk), .cnt_rst(rst), .cnt_en(en), .cnt_dir(dir), .cnt_load(load),
        .cnt_load_val(load_val), .cnt_set_mode(set_mode), .cnt_set_inc(set_inc),
        .cnt_set_dec(set_dec), .cnt_value(a_value), .cnt_tens(a_tens), .cnt_ones(a_ones),
        .cnt_tc(a_tc), .cnt_carry(a_carry), .cnt_borrow(a_borrow), .cnt_load_err(a_err)
    );

    modn_counter #(.MODULUS(24), .WIDTH(5), .RESET_VAL(5)) dut_b (
        .cnt_clk(clk), .cnt_rst(rst), .cnt_en(en), .cnt_dir(dir), .cnt_load(load),
        .cnt_load_val(load_val[4:0]), .cnt_set_mode(set_mode), .cnt_set_inc(set_inc),
        .cnt_set_dec(set_dec), .cnt_value(b_value), .cnt_tens(b_tens), .cnt_ones(b_ones),
        .cnt_tc(b_tc), .cnt_carry(b_carry), .cnt_borrow(b_borrow), .cnt_load_err(b_err)
    );

    typedef struct packed {
        logic [1:0][7:0] val;
        logic [1:0][3:0] tens;
        logic [1:0][3:0] ones;
        logic [1:0]      tc;
        logic [1:0]      carry;
        logic [1:0]      borrow;
        logic [1:0]      err;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int mods[2] = '{60, 24};
    int masks[2] = '{127, 31};
    int rvs[2] = '{0, 5};
    int m_val[2] = '{0, 0};
    bit m_set = 1'b0, m_pinc = 1'b0, m_pdec = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ld, input int lv, input bit md,
                        input bit inc, input bit dec, input bit e, input bit d);
        exp_t x;
        x = '0;
        @(negedge clk);
        rst = r; load = ld; load_val = 7'(lv); set_mode = md;
        set_inc = inc; set_dec = dec; en = e; dir = d;
        for (int k = 0; k < 2; k++) begin
            int m;
            int l;
            m = mods[k];
            l = lv & masks[k];
            if (r) begin
                m_val[k] = rvs[k];
            end else if (ld) begin
                if (l < m) m_val[k] = l;
                else x.err[k] = 1'b1;
            end else if (m_set) begin
                if (inc && !m_pinc && !(dec && !m_pdec)) m_val[k] = (m_val[k] + 1) % m;
                else if (dec && !m_pdec && !(inc && !m_pinc)) m_val[k] = (m_val[k] + m - 1) % m;
            end else if (e) begin
                if (!d) begin
                    x.carry[k] = (m_val[k] == m - 1);
                    m_val[k]   = (m_val[k] + 1) % m;
                end else begin
                    x.borrow[k] = (m_val[k] == 0);
                    m_val[k]    = (m_val[k] + m - 1) % m;
                end
            end
        end
        m_set  = r ? 1'b0 : md;
        m_pinc = r ? 1'b0 : inc;
        m_pdec = r ? 1'b0 : dec;
        for (int k = 0; k < 2; k++) begin
            x.val[k]  = 8'(m_val[k]);
            x.tens[k] = 4'(m_val[k] / 10);
            x.ones[k] = 4'(m_val[k] % 10);
            x.tc[k]   = !m_set && (d ? (m_val[k] == 0) : (m_val[k] == mods[k] - 1));
        end
        q.push_back(x);
    endtask

    // Monitor: DUT presents a registered result every edge
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mx = q.pop_front();
            chk("a_value", int'(a_value), int'(mx.val[0]));
            chk("a_tens", int'(a_tens), int'(mx.tens[0]));
            chk("a_ones", int'(a_ones), int'(mx.ones[0]));
            chk("a_tc", int'(a_tc), int'(mx.tc[0]));
            chk("a_carry", int'(a_carry), int'(mx.carry[0]));
            chk("a_borrow", int'(a_borrow), int'(mx.borrow[0]));
            chk("a_load_err", int'(a_err), int'(mx.err[0]));
            chk("b_value", int'(b_value), int'(mx.val[1]));
            chk("b_tens", int'(b_tens), int'(mx.tens[1]));
            chk("b_ones", int'(b_ones), int'(mx.ones[1]));
            chk("b_tc", int'(b_tc), int'(mx.tc[1]));
            chk("b_carry", int'(b_carry), int'(mx.carry[1]));
            chk("b_borrow", int'(b_borrow), int'(mx.borrow[1]));
            chk("b_load_err", int'(b_err), int'(mx.err[1]));
        end
    end

    initial begin
        bit md;
        // Reset, then full up-count wrap
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (61) step(0, 0, 0, 0, 0, 0, 1, 0);
        // Down from 0 wraps with borrow
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        // Good and bad loads
        step(0, 1, 42, 0, 0, 0, 0, 0);
        step(0, 1, 60, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // SET: held inc at 59 steps once, simultaneous edges cancel
        step(0, 1, 59, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset wins over an illegal load
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 60, 0, 0, 0, 1, 0);
        // Mod-24 instance wraps 23 -> 0
        step(0, 1, 23, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);
        // Randomized traffic
        md = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, int'($urandom_range(0, 127)),
                 md, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
